counter_100: RTL and testbench

COUNTER_100 -- requirements
Module: counter_100

---
 rtl/counter_100.sv | 90 +++++++++
 tb/tb_counter_100.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/counter_100.sv
// Three-digit BCD up/down counter that wraps between 000 and MAX_COUNT.
// Reset clears asynchronously; release is resynchronised so counting resumes on the second edge.
module counter_100 #(
    parameter int MAX_COUNT = 100
) (
    input  logic       CE,
    input  logic       RESET,
    input  logic       REVERSE,
    output logic [3:0] CNT1,
    output logic [3:0] CNT2,
    output logic [3:0] CNT3
);

    localparam logic [11:0] MAX_BCD = {4'(MAX_COUNT / 100),
                                       4'((MAX_COUNT / 10) % 10),
                                       4'(MAX_COUNT % 10)};

    logic [11:0] value_reg;
    logic [11:0] value_next;
    logic [11:0] up_value;
    logic [11:0] down_value;
    logic [2:0]  digit_valid;
    logic [2:0]  is_nine;
    logic [2:0]  is_zero;
    logic        run_reg;
    logic        at_max;
    logic        at_zero;
    logic        out_of_range;

    // Per-digit BCD step: a digit moves only when every lower digit rolls over.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            logic [3:0] digit;
            logic       carry;
            logic       borrow;

            assign digit           = value_reg[gi*4 +: 4];
            assign digit_valid[gi] = (digit <= 4'd9);
            assign is_nine[gi]     = (digit == 4'd9);
            assign is_zero[gi]     = (digit == 4'd0);

            if (gi == 0) begin : g_lsd
                assign carry  = 1'b1;
                assign borrow = 1'b1;
            end else begin : g_upper
                assign carry  = &is_nine[gi-1:0];
                assign borrow = &is_zero[gi-1:0];
            end

            assign up_value[gi*4 +: 4]   = (carry && is_nine[gi]) ? 4'd0
                                         : digit + {3'b000, carry};
            assign down_value[gi*4 +: 4] = (borrow && is_zero[gi]) ? 4'd9
                                         : digit - {3'b000, borrow};
        end
    endgenerate

    // With every digit in 0..9 the packed BCD word orders the same as its decimal value.
    assign at_max       = (value_reg == MAX_BCD);
    assign at_zero      = (value_reg == 12'h000);
    assign out_of_range = !(&digit_valid) || (value_reg > MAX_BCD);

    always_comb begin
        value_next = value_reg;
        if (out_of_range) begin
            value_next = 12'h000;
        end else if (REVERSE) begin
            value_next = at_zero ? MAX_BCD : down_value;
        end else begin
            value_next = at_max ? 12'h000 : up_value;
        end
    end

    always_ff @(posedge CE or negedge RESET) begin
        if (!RESET) begin
            run_reg   <= 1'b0;
            value_reg <= 12'h000;
        end else begin
            run_reg <= 1'b1;
            if (run_reg) begin
                value_reg <= value_next;
            end
        end
    end

    assign CNT1 = value_reg[3:0];
    assign CNT2 = value_reg[7:4];
    assign CNT3 = value_reg[11:8];

endmodule

// File: tb/tb_counter_100.sv
// Bench for counter_100: two instances (MAX_COUNT 100 and 999) share stimulus and are
// checked against a vector table, hand-written corner sequences and a randomized reference model.
module tb_counter_100;

    logic       ce = 1'b0;
    logic       reset = 1'b1;
    logic       reverse = 1'b0;
    logic [3:0] a_cnt1, a_cnt2, a_cnt3;
    logic [3:0] b_cnt1, b_cnt2, b_cnt3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ce = ~ce;

    counter_100 #(.MAX_COUNT(100)) dut_100 (
        .CE(ce), .RESET(reset), .REVERSE(reverse),
        .CNT1(a_cnt1), .CNT2(a_cnt2), .CNT3(a_cnt3)
    );

    counter_100 #(.MAX_COUNT(999)) dut_999 (
        .CE(ce), .RESET(reset), .REVERSE(reverse),
        .CNT1(b_cnt1), .CNT2(b_cnt2), .CNT3(b_cnt3)
    );

    typedef struct {
        logic rst;
        logic rev;
        int   e100;
        int   e999;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int model_step(input int v, input int max_count, input logic rev);
        if (rev) return (v == 0) ? max_count : v - 1;
        return (v == max_count) ? 0 : v + 1;
    endfunction

    task automatic check(input string name, input int e100, input int e999);
        logic [11:0] got100;
        logic [11:0] got999;
        got100 = {a_cnt3, a_cnt2, a_cnt1};
        got999 = {b_cnt3, b_cnt2, b_cnt1};
        $display("[%0t] %s rst=%b rev=%b max100=%h max999=%h", $time, name, reset, reverse,
                 got100, got999);
        n_checks++;
        if (got100 !== to_bcd(e100)) begin
            n_fail++;
            $display("FAIL %s max100: got %h expected %h", name, got100, to_bcd(e100));
        end
        n_checks++;
        if (got999 !== to_bcd(e999)) begin
            n_fail++;
            $display("FAIL %s max999: got %h expected %h", name, got999, to_bcd(e999));
        end
    endtask

    task automatic edge_wait();
        @(posedge ce);
        #2;
    endtask

    // Clears both counters, then releases with the given direction; the release edge must not count.
    task automatic do_reset(input logic rev);
        reset = 1'b0;
        edge_wait();
        check("reset_hold", 0, 0);
        reset   = 1'b1;
        reverse = rev;
        edge_wait();
        check("release_no_count", 0, 0);
    endtask

    initial begin
        int   m100;
        int   m999;
        bit   run;
        logic r_rst;
        logic r_rev;

        vecs[0] = '{1'b1, 1'b1,   0,   0};
        vecs[1] = '{1'b1, 1'b1, 100, 999};
        vecs[2] = '{1'b1, 1'b1,  99, 998};
        vecs[3] = '{1'b1, 1'b0, 100, 999};
        vecs[4] = '{1'b1, 1'b0,   0,   0};
        vecs[5] = '{1'b1, 1'b1, 100, 999};
        vecs[6] = '{1'b1, 1'b0,   0,   0};
        vecs[7] = '{1'b0, 1'b1,   0,   0};
        vecs[8] = '{1'b1, 1'b1,   0,   0};
        vecs[9] = '{1'b1, 1'b1, 100, 999};

        #1 reset = 1'b0;
        #1 check("reset_state", 0, 0);
        edge_wait();
        check("reset_hold", 0, 0);

        for (int i = 0; i < 10; i++) begin
            reset   = vecs[i].rst;
            reverse = vecs[i].rev;
            edge_wait();
            check($sformatf("vec%0d", i), vecs[i].e100, vecs[i].e999);
        end

        // Full up sweep through both carries and the wrap at 100.
        do_reset(1'b0);
        for (int i = 1; i <= 101; i++) begin
            edge_wait();
            check("up", i % 101, i);
        end

        // Down from 000: wrap to MAX, then borrows at 100->099 and 090->089.
        do_reset(1'b1);
        for (int j = 1; j <= 12; j++) begin
            edge_wait();
            check("down", (101 - j) % 101, (1000 - j) % 1000);
        end

        // Direction switch at 057.
        do_reset(1'b0);
        for (int i = 1; i <= 57; i++) begin
            edge_wait();
            check("to57", i, i);
        end
        reverse = 1'b1;
        edge_wait();
        check("switch_down", 56, 56);
        edge_wait();
        check("switch_down", 55, 55);
        reverse = 1'b0;
        edge_wait();
        check("switch_up", 56, 56);
        edge_wait();
        check("switch_up", 57, 57);

        // Asynchronous clear between edges, then held through edges.
        #1 reset = 1'b0;
        #1 check("async_reset", 0, 0);
        reverse = 1'b1;
        edge_wait();
        check("reset_hold_rev", 0, 0);
        reverse = 1'b0;
        edge_wait();
        check("reset_hold_fwd", 0, 0);

        reset   = 1'b1;
        reverse = 1'($urandom_range(0, 1));
        edge_wait();
        check("release_no_count", 0, 0);

        m100 = 0;
        m999 = 0;
        run  = 1'b1;
        for (int k = 0; k < 400; k++) begin
            r_rst   = ($urandom_range(0, 29) != 0);
            r_rev   = 1'($urandom_range(0, 1));
            reset   = r_rst;
            reverse = r_rev;
            edge_wait();
            if (!r_rst) begin
                m100 = 0;
                m999 = 0;
                run  = 1'b0;
            end else if (!run) begin
                run = 1'b1;
            end else begin
                m100 = model_step(m100, 100, r_rev);
                m999 = model_step(m999, 999, r_rev);
            end
            check("random", m100, m999);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
